pulse_gen: RTL and testbench
============================

Name: pulse_gen

Overview:
- Programmable periodic strobe generator: emits a single-cycle high pulse on `out` once every `ticks` enabled clock cycles.
- Used as a timebase or tick source for downstream DSP/control blocks, e.g. a 10 us strobe from a 12 MHz clock with ticks=120.
- Purely synchronous; one clock domain.

Parameters:
- N, default 8, width of the `ticks` input and of the internal cycle counter. Legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk).
- ena  input  1  count enable; 1 = run, 0 = hold idle.
- ticks  input  N  pulse period in clk cycles, unsigned; sampled every cycle.
- out  output  1  registered strobe; high for exactly one cycle per period.

Behaviour:
- Reset is synchronous and active-low. On a rising clk with rst=0:
  - counter <= 0, out <= 0.
  - rst has priority over ena and ticks.
- Internal state is an N-bit counter `cnt`. `out` is a flop, not combinational.
- On each rising clk with rst=1 and ena=1 and ticks!=0:
  - If cnt >= ticks-1: out <= 1, cnt <= 0.
  - Else: out <= 0, cnt <= cnt+1.
- Comparison uses >=, so lowering `ticks` mid-count below the current cnt produces a pulse on the next edge, then wraps.
- Latency: with ena=1 from reset release, the first out=1 follows the ticks-th enabled rising edge. Subsequent pulses are exactly `ticks` cycles apart (rising edge to rising edge).
- ticks=1: out=1 on every enabled cycle (continuous high).
- ticks=0: the generator is disabled. cnt <= 0, out <= 0, no pulses.
- ena=0 (rst=1): cnt <= 0, out <= 0 on the next edge. An in-progress strobe ends after its single cycle and is never stretched.
- Re-enable after ena=0: counting restarts from 0. The first pulse comes `ticks` enabled cycles later.
- ticks = 2^N-1 is the maximum period. cnt never overflows because it wraps via the compare.
- Changing `ticks` takes effect immediately on the next compare; no latching.
- No X propagation: all flops have defined reset values.

Test Plan:
- N=7, ticks=120, ena=1, rst=0 for 2 cycles then 1; run 1200 cycles -> exactly 10 single-cycle pulses.
  - First pulse follows the 120th edge after reset release.
  - Pulses are spaced exactly 120 cycles apart.
- Same setup: drop ena=0 at a negedge, run 240 cycles -> out stays 0 throughout. Re-assert ena=1 -> next pulse after exactly 120 cycles.
- ticks=1, ena=1 -> out=1 every cycle after the first edge. ticks=2 -> out toggles 0,1,0,1.
- ticks=0, ena=1 for 50 cycles -> out stays 0.
- Reset mid-count: assert rst=0 at cnt≈60 with ticks=120 -> out=0 on the next edge. After release, the first pulse comes 120 cycles later.
- Period shrink: ticks=120, at cnt=100 change ticks to 50 -> pulse on the next edge, then pulses every 50 cycles.

Source files
------------

// File: rtl/pulse_gen.sv
// pulse_gen: programmable periodic strobe generator.
// Emits a single-cycle registered pulse on `out` once every `ticks` enabled
// clock cycles. ticks == 0 or ena == 0 parks the generator with the counter
// cleared, so re-enabling always starts a fresh, full-length period.
module pulse_gen #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] ticks,
  output logic         out
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         out_q;
  logic         out_d;
  logic         run;
  logic         wrap;

  // True once the current period has used up its last cycle. A >= compare
  // (not ==) makes a mid-count shrink of ticks wrap on the very next edge
  // instead of running the counter all the way round.
  function automatic logic period_done(input logic [N-1:0] cnt,
                                       input logic [N-1:0] per);
    return cnt >= (per - N'(1));
  endfunction

  // Next-state: count while running, wrap with a strobe at end of period.
  always_comb begin
    cnt_d = '0;
    out_d = 1'b0;
    run   = ena && (ticks != '0);
    wrap  = period_done(cnt_q, ticks);
    if (run) begin
      if (wrap) begin
        out_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end
  end

  // State registers; synchronous active-low reset wins over ena and ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Testbench for pulse_gen (N=7): directed scenarios plus randomized traffic,
// each cycle compared with an edge-counting reference model.
module tb_pulse_gen;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic [N-1:0] ticks = '0;
  logic         out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: number of enabled edges seen in the current period;
  // a strobe is due when that number reaches the requested period.
  int m_run = 0;
  bit m_out = 1'b0;

  pulse_gen #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .ticks(ticks),
    .out  (out)
  );

  always #5 clk = ~clk;

  // Advance one clock: model sees the same inputs as the DUT at the edge,
  // then return at the falling edge where outputs are sampled and inputs change.
  task automatic cyc();
    @(posedge clk);
    if (!rst || !ena || ticks == 0) begin
      m_run = 0;
      m_out = 1'b0;
    end else begin
      m_run = m_run + 1;
      if (m_run >= int'(ticks)) begin
        m_out = 1'b1;
        m_run = 0;
      end else begin
        m_out = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; ticks = 7'd120;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (out !== 1'b0) $display("FAIL reset_out cycle %0d: got %b want 0", i, out);
      else n_pass++;
    end
  endtask

  task automatic test_period();
    int pulses = 0;
    int first = -1;
    int last = -1;
    int bad_gap = 0;
    rst = 1'b1;
    for (int e = 1; e <= 1200; e++) begin
      cyc();
      n_checks++;
      if (out !== m_out) $display("FAIL period_model edge %0d: got %b want %b", e, out, m_out);
      else n_pass++;
      if (out === 1'b1) begin
        pulses++;
        if (first < 0) first = e;
        if (last >= 0 && e - last != 120) bad_gap++;
        last = e;
      end
    end
    n_checks++;
    if (pulses != 10) $display("FAIL period_count: got %0d want 10", pulses);
    else n_pass++;
    n_checks++;
    if (first != 120) $display("FAIL period_first: got %0d want 120", first);
    else n_pass++;
    n_checks++;
    if (bad_gap != 0) $display("FAIL period_spacing: got %0d bad gaps want 0", bad_gap);
    else n_pass++;
  endtask

  task automatic test_ena_drop();
    int seen = 0;
    int wait_e = 0;
    ena = 1'b0;
    for (int i = 0; i < 240; i++) begin
      cyc();
      if (out !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL ena_low_quiet: got %0d high cycles want 0", seen);
    else n_pass++;
    ena = 1'b1;
    while (wait_e < 300) begin
      cyc();
      wait_e++;
      if (out === 1'b1) break;
    end
    n_checks++;
    if (wait_e != 120) $display("FAIL ena_restart_latency: got %0d want 120", wait_e);
    else n_pass++;
  endtask

  task automatic test_ticks_small();
    ticks = 7'd1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (out !== 1'b1) $display("FAIL ticks1 cycle %0d: got %b want 1", i, out);
      else n_pass++;
    end
    // Switch to 2 from a cleared counter so the pattern phase is known.
    ena = 1'b0;
    cyc();
    ena = 1'b1; ticks = 7'd2;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (out !== 1'(i % 2)) $display("FAIL ticks2 cycle %0d: got %b want %b", i, out, 1'(i % 2));
      else n_pass++;
    end
  endtask

  task automatic test_ticks_zero();
    int seen = 0;
    ticks = 7'd0; ena = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (out !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL ticks0_quiet: got %0d high cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wait_e = 0;
    ticks = 7'd120; ena = 1'b1;
    for (int i = 0; i < 60; i++) cyc();
    rst = 1'b0;
    cyc();
    n_checks++;
    if (out !== 1'b0) $display("FAIL reset_mid_out: got %b want 0", out);
    else n_pass++;
    rst = 1'b1;
    while (wait_e < 300) begin
      cyc();
      wait_e++;
      if (out === 1'b1) break;
    end
    n_checks++;
    if (wait_e != 120) $display("FAIL reset_mid_latency: got %0d want 120", wait_e);
    else n_pass++;
  endtask

  task automatic test_shrink();
    int last;
    int wait_e;
    // Entered right after a strobe, so the count restarts from 0 here.
    for (int i = 0; i < 100; i++) cyc();
    ticks = 7'd50;
    cyc();
    n_checks++;
    if (out !== 1'b1) $display("FAIL shrink_immediate: got %b want 1", out);
    else n_pass++;
    for (int p = 0; p < 3; p++) begin
      wait_e = 0;
      while (wait_e < 200) begin
        cyc();
        wait_e++;
        if (out === 1'b1) break;
      end
      last = wait_e;
      n_checks++;
      if (last != 50) $display("FAIL shrink_spacing pulse %0d: got %0d want 50", p, last);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) ticks = N'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) ticks = 7'd127;
      cyc();
      n_checks++;
      if (out !== m_out) $display("FAIL random_model cycle %0d: got %b want %b", i, out, m_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_ena_drop();
    test_ticks_small();
    test_ticks_zero();
    test_reset_mid();
    test_shrink();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
